// File: rtl/vc_switch_alloc.sv
// vc_switch_alloc: locks the output port to one virtual channel for a whole
// packet, forwards flits against a downstream credit counter and releases on
// the tail flit or when the packet-length watchdog expires.
module vc_switch_alloc #(
  parameter int NUM_VC      = 8,
  parameter int CREDIT_MAX  = 4,
  parameter int MAX_PKT_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_any,
  input  logic [2:0]        req_vc,
  input  logic [NUM_VC-1:0] vc_flit_valid,
  input  logic [NUM_VC-1:0] vc_flit_tail,
  input  logic              credit_ret,
  output logic              grant_valid,
  output logic [2:0]        grant_vc,
  output logic [NUM_VC-1:0] flit_pop,
  output logic [2:0]        credits,
  output logic              busy,
  output logic              err_credit,
  output logic              err_len
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state;
  logic [2:0]        grantVc;
  logic [7:0]        flitCnt;
  logic [2:0]        creditCnt;
  logic              errCredit;
  logic              errLen;
  logic [NUM_VC-1:0] vcSel;
  logic              selValid;
  logic              selTail;
  logic              pop;
  logic              wdHit;

  // One-hot decode of the locked VC; indexing through a mask keeps an
  // out-of-range grantVc harmless when NUM_VC < 8.
  for (genvar i = 0; i < NUM_VC; i++) begin : g_sel
    assign vcSel[i] = (grantVc == 3'(i));
  end

  assign selValid = |(vc_flit_valid & vcSel);
  assign selTail  = |(vc_flit_tail & vcSel);

  // Zero credits blocks the pop, so the counter can never underflow.
  assign pop   = (state == LOCKED) && selValid && (creditCnt != 3'd0);
  assign wdHit = (flitCnt + 8'd1) == 8'(MAX_PKT_LEN);

  assign flit_pop    = pop ? vcSel : '0;
  assign grant_valid = (state == LOCKED);
  assign busy        = (state == LOCKED);
  assign grant_vc    = grantVc;
  assign credits     = creditCnt;
  assign err_credit  = errCredit;
  assign err_len     = errLen;

  // Lock FSM: sample the chain in IDLE, hold the VC until tail or watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grantVc <= 3'd0;
      flitCnt <= 8'd0;
      errLen  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            grantVc <= req_vc;
            flitCnt <= 8'd0;
            state   <= LOCKED;
          end
        end
        LOCKED: begin
          if (pop) begin
            flitCnt <= flitCnt + 8'd1;
            if (selTail) begin
              state <= IDLE;
            end else if (wdHit) begin
              state  <= IDLE;
              errLen <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Credit counter persists across packets; a return at the ceiling is
  // dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      creditCnt <= 3'(CREDIT_MAX);
      errCredit <= 1'b0;
    end else if (pop && !credit_ret) begin
      creditCnt <= creditCnt - 3'd1;
    end else if (!pop && credit_ret) begin
      if (creditCnt == 3'(CREDIT_MAX)) errCredit <= 1'b1;
      else                             creditCnt <= creditCnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_vc_switch_alloc.sv
// Bench for vc_switch_alloc: directed packet scenarios plus random traffic,
// every cycle compared against a packet-level model of the allocator.
module tb_vc_switch_alloc;
  localparam int NVC  = 8;
  localparam int CMAX = 4;
  localparam int MAXL = 16;

  logic           clk, rst;
  logic           req_any, credit_ret;
  logic [2:0]     req_vc;
  logic [NVC-1:0] vc_flit_valid, vc_flit_tail;
  logic           grant_valid, busy, err_credit, err_len;
  logic [2:0]     grant_vc, credits;
  logic [NVC-1:0] flit_pop;

  vc_switch_alloc #(.NUM_VC(NVC), .CREDIT_MAX(CMAX), .MAX_PKT_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .req_any(req_any), .req_vc(req_vc),
    .vc_flit_valid(vc_flit_valid), .vc_flit_tail(vc_flit_tail),
    .credit_ret(credit_ret), .grant_valid(grant_valid), .grant_vc(grant_vc),
    .flit_pop(flit_pop), .credits(credits), .busy(busy),
    .err_credit(err_credit), .err_len(err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmpCnt = 0;
  int failCnt = 0;

  // Model: who owns the port, flits sent in this packet, credit pool, errors.
  bit mLocked;
  int mVc, mSent, mCred;
  bit mErrC, mErrL;

  // Per-VC buffer contents for directed tests: flits queued, packet ends in tail.
  int rem[NVC];
  bit tailOn[NVC];
  bit bufMode;
  logic [NVC-1:0] lastPop;
  int popCnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmpCnt++;
    if (act !== exp) begin
      failCnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearBufs();
    for (int i = 0; i < NVC; i++) begin
      rem[i] = 0;
      tailOn[i] = 1'b0;
    end
  endtask

  // Called at posedge+1; resets mid-cycle so the asynchronous drop is visible.
  task automatic doReset();
    rst = 1'b1;
    #1;
    chk("rst flit_pop", 32'(flit_pop), 32'h0);
    chk("rst grant_valid", 32'(grant_valid), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst grant_vc", 32'(grant_vc), 32'h0);
    chk("rst credits", 32'(credits), 32'(CMAX));
    chk("rst err_credit", 32'(err_credit), 32'h0);
    chk("rst err_len", 32'(err_len), 32'h0);
    mLocked = 1'b0; mVc = 0; mSent = 0; mCred = CMAX; mErrC = 1'b0; mErrL = 1'b0;
    clearBufs();
    #2;
    rst = 1'b0;
    req_any = 1'b0; req_vc = 3'd0; credit_ret = 1'b0;
    vc_flit_valid = '0; vc_flit_tail = '0;
    @(posedge clk); #1;
  endtask

  // One clock cycle: drive inputs, compare outputs at the falling edge, then
  // advance the model to what the next rising edge must produce.
  task automatic cyc(input bit ra, input logic [2:0] rv, input bit cr);
    bit expPop;
    logic [NVC-1:0] expFp;
    req_any = ra; req_vc = rv; credit_ret = cr;
    if (bufMode) begin
      for (int i = 0; i < NVC; i++) begin
        vc_flit_valid[i] = rem[i] > 0;
        vc_flit_tail[i]  = tailOn[i] && rem[i] == 1;
      end
    end
    @(negedge clk);
    expPop = mLocked && vc_flit_valid[mVc] && mCred > 0;
    expFp  = expPop ? (NVC'(1) << mVc) : '0;
    chk("flit_pop", 32'(flit_pop), 32'(expFp));
    chk("grant_valid", 32'(grant_valid), 32'(mLocked));
    chk("busy", 32'(busy), 32'(mLocked));
    if (mLocked) chk("grant_vc", 32'(grant_vc), 32'(mVc));
    chk("credits", 32'(credits), 32'(mCred));
    chk("err_credit", 32'(err_credit), 32'(mErrC));
    chk("err_len", 32'(err_len), 32'(mErrL));
    lastPop = flit_pop;
    if (flit_pop != '0) popCnt++;
    if (bufMode && expPop) rem[mVc]--;
    if (!mLocked) begin
      if (ra) begin mLocked = 1'b1; mVc = int'(rv); mSent = 0; end
    end else if (expPop) begin
      mSent++;
      if (vc_flit_tail[mVc]) mLocked = 1'b0;
      else if (mSent == MAXL) begin mLocked = 1'b0; mErrL = 1'b1; end
    end
    if (cr && !expPop && mCred == CMAX) mErrC = 1'b1;
    else mCred = mCred + int'(cr) - int'(expPop);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req_any = 1'b0; req_vc = 3'd0; credit_ret = 1'b0;
    vc_flit_valid = '0; vc_flit_tail = '0; bufMode = 1'b1; popCnt = 0;
    doReset();

    // 3-flit packet on VC5.
    rem[5] = 3; tailOn[5] = 1'b1;
    cyc(1, 3'd5, 0);
    chk("t1 granted", 32'(grant_valid), 32'h1);
    chk("t1 vc", 32'(grant_vc), 32'h5);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 3'd0, 0);
      chk("t1 pop", 32'(lastPop), 32'h20);
    end
    chk("t1 credits", 32'(credits), 32'h1);
    chk("t1 released", 32'(grant_valid), 32'h0);

    // 6-flit packet on VC2 with credit starvation.
    doReset();
    rem[2] = 6; tailOn[2] = 1'b1;
    cyc(1, 3'd2, 0);
    popCnt = 0;
    repeat (4) cyc(0, 3'd0, 0);
    chk("t2 four pops", 32'(popCnt), 32'h4);
    cyc(0, 3'd0, 0);
    chk("t2 stall credits", 32'(credits), 32'h0);
    chk("t2 stall locked", 32'(grant_valid), 32'h1);
    chk("t2 stall no pop", 32'(lastPop), 32'h0);
    cyc(0, 3'd0, 1);
    cyc(0, 3'd0, 0);
    cyc(0, 3'd0, 1);
    cyc(0, 3'd0, 0);
    chk("t2 six pops", 32'(popCnt), 32'h6);
    chk("t2 released", 32'(grant_valid), 32'h0);

    // Requests ignored while locked; one bubble before the next grant.
    doReset();
    rem[1] = 3; tailOn[1] = 1'b1; rem[0] = 2; tailOn[0] = 1'b1;
    cyc(1, 3'd1, 0);
    chk("t3 vc1", 32'(grant_vc), 32'h1);
    cyc(1, 3'd0, 0);
    chk("t3 hold1", 32'({grant_valid, grant_vc}), 32'h9);
    cyc(1, 3'd0, 0);
    chk("t3 hold2", 32'({grant_valid, grant_vc}), 32'h9);
    cyc(1, 3'd0, 0);
    chk("t3 bubble", 32'(grant_valid), 32'h0);
    cyc(1, 3'd0, 0);
    chk("t3 regrant", 32'({grant_valid, grant_vc}), 32'h8);

    // Simultaneous pop and credit return, then reset mid-packet.
    doReset();
    rem[4] = 10;
    cyc(1, 3'd4, 0);
    cyc(0, 3'd0, 0);
    cyc(0, 3'd0, 0);
    chk("t4 credits2", 32'(credits), 32'h2);
    cyc(0, 3'd0, 1);
    chk("t4 pop", 32'(lastPop), 32'h10);
    chk("t4 credits hold", 32'(credits), 32'h2);
    doReset();
    rem[6] = 1; tailOn[6] = 1'b1;
    cyc(1, 3'd6, 0);
    chk("t6 regrant", 32'({grant_valid, grant_vc}), 32'he);
    cyc(0, 3'd0, 0);
    chk("t6 single pop", 32'(lastPop), 32'h40);
    chk("t6 single release", 32'(grant_valid), 32'h0);
    cyc(0, 3'd0, 1);
    chk("t4 no err yet", 32'(err_credit), 32'h0);
    cyc(0, 3'd0, 1);
    chk("t4 ceiling", 32'(credits), 32'h4);
    chk("t4 err_credit", 32'(err_credit), 32'h1);
    cyc(0, 3'd0, 0);
    chk("t4 err sticky", 32'(err_credit), 32'h1);

    // Watchdog: 16 non-tail flits on VC3.
    doReset();
    rem[3] = 100;
    cyc(1, 3'd3, 0);
    popCnt = 0;
    repeat (15) cyc(0, 3'd0, 1);
    chk("t5 still locked", 32'(grant_valid), 32'h1);
    chk("t5 no err yet", 32'(err_len), 32'h0);
    cyc(0, 3'd0, 1);
    chk("t5 pops", 32'(popCnt), 32'h10);
    chk("t5 released", 32'(grant_valid), 32'h0);
    chk("t5 err_len", 32'(err_len), 32'h1);
    chk("t5 credits", 32'(credits), 32'h4);
    cyc(0, 3'd0, 0);
    chk("t5 err sticky", 32'(err_len), 32'h1);

    // Random traffic, periodically reset so sticky errors re-arm.
    bufMode = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) doReset();
      vc_flit_valid = NVC'($urandom | $urandom);
      vc_flit_tail  = NVC'($urandom & $urandom & $urandom);
      cyc(($urandom_range(0, 2) != 0), 3'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", cmpCnt - failCnt, cmpCnt);
    $finish;
  end
endmodule
